mem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port synchronous `memory` block (16-bit address, 8-bit data, one-cycle registered read). It shares the RAM between requester 0 (CPU core bus) and requester 1 (block-transfer/DMA engine). It uses fixed priority for requester 0 with a bounded-starvation override for requester 1. It also routes the delayed read data back to the requester that issued the read.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/arb_age_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory arbiters.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int WAIT_W     = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    // Increment that sticks at the limit instead of wrapping.
    function automatic logic [WAIT_W-1:0] sat_inc(
        input logic [WAIT_W-1:0] cnt,
        input logic [WAIT_W-1:0] lim
    );
        logic [WAIT_W-1:0] res;
        if (cnt >= lim) begin
            res = lim;
        end else begin
            res = cnt + WAIT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and memory-side signals of the two-port memory arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_re;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_re, mem_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
               mem_addr, mem_din, mem_re, mem_we
    );

endinterface

// File: rtl/arb_age_counter.sv
// Saturating age counter: counts consecutive denied cycles up to MAX_WAIT.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic              sat,
    output logic [WAIT_W-1:0] count
);

    localparam logic [WAIT_W-1:0] MAX_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_r;

    // Age register; clear has priority over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {WAIT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {WAIT_W{1'b0}};
        end else if (inc) begin
            cnt_r <= sat_inc(cnt_r, MAX_C);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat   = (cnt_r == MAX_C);
    assign count = cnt_r;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: CPU has priority,
// DMA is forced through after MAX_WAIT denied cycles; read data is steered by owner.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    logic              gnt0_s;
    logic              gnt1_s;
    logic              sat_s;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_din_s;
    logic              mem_re_s;
    logic              mem_we_s;
    logic [1:0]        rd_pend_r;

    arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (bus.req1 & ~gnt1_s),
        .clr   (gnt1_s | ~bus.req1),
        .sat   (sat_s),
        .count (wait_cnt_s)
    );

    // Grant selection: starved DMA first, then CPU, then DMA; nothing in reset.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_n) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (bus.req1 && sat_s) begin
            gnt1_s = 1'b1;
        end else if (bus.req0) begin
            gnt0_s = 1'b1;
        end else if (bus.req1) begin
            gnt1_s = 1'b1;
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Memory port mux; idle cycles leave the CPU address/data on the bus.
    always_comb begin
        mem_addr_s = bus.addr0;
        mem_din_s  = bus.wdata0;
        mem_re_s   = 1'b0;
        mem_we_s   = 1'b0;
        if (gnt1_s) begin
            mem_addr_s = bus.addr1;
            mem_din_s  = bus.wdata1;
            mem_we_s   = bus.we1;
            mem_re_s   = ~bus.we1;
        end else if (gnt0_s) begin
            mem_we_s   = bus.we0;
            mem_re_s   = ~bus.we0;
        end else begin
            mem_re_s   = 1'b0;
            mem_we_s   = 1'b0;
        end
    end

    // Remembers which requester owns the read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend_r <= 2'b00;
        end else begin
            rd_pend_r <= {gnt1_s & ~bus.we1, gnt0_s & ~bus.we0};
        end
    end

    assign bus.gnt0     = gnt0_s;
    assign bus.gnt1     = gnt1_s;
    assign bus.mem_addr = mem_addr_s;
    assign bus.mem_din  = mem_din_s;
    assign bus.mem_re   = mem_re_s;
    assign bus.mem_we   = mem_we_s;
    assign bus.rvalid0  = rd_pend_r[REQ_CPU];
    assign bus.rvalid1  = rd_pend_r[REQ_DMA];
    assign bus.rdata0   = bus.mem_dout;
    assign bus.rdata1   = bus.mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences and
// random traffic against a cycle-level reference model with a behavioural RAM.
module tb_mem_arbiter;

    localparam int MAXW = 4;

    logic clk;
    logic rst_n;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (8),
        .MAX_WAIT (MAXW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with one-cycle registered read.
    logic [7:0] mem [0:65535];
    logic [7:0] dout_r;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        if (bus.mem_re) dout_r <= mem[bus.mem_addr];
    end
    assign bus.mem_dout = dout_r;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    int         streak = 0;
    bit         pend0  = 1'b0;
    bit         pend1  = 1'b0;
    logic [7:0] pdata0 = 8'h00;
    logic [7:0] pdata1 = 8'h00;
    logic [7:0] ref_mem [int];
    int         last_grant = 0;

    logic [15:0] addr_tab [8];

    typedef struct {
        bit          rst_n;
        bit          req0;
        bit          we0;
        logic [15:0] addr0;
        logic [7:0]  wdata0;
        bit          req1;
        bit          we1;
        logic [15:0] addr1;
        logic [7:0]  wdata1;
        bit          exp_gnt0;
        bit          exp_gnt1;
        bit          exp_re;
        bit          exp_we;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // 0 = none, 1 = CPU, 2 = DMA
    function automatic int exp_grant();
        if (!rst_n) return 0;
        if (bus.req1 && streak == MAXW) return 2;
        if (bus.req0) return 1;
        if (bus.req1) return 2;
        return 0;
    endfunction

    task automatic set_in(input bit r0, input bit w0, input logic [15:0] a0, input logic [7:0] d0,
                          input bit r1, input bit w1, input logic [15:0] a1, input logic [7:0] d1);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    endtask

    task automatic model_check();
        int g;
        bit ewe, ere;
        g   = exp_grant();
        ewe = (g == 1) ? bus.we0 : (g == 2) ? bus.we1 : 1'b0;
        ere = (g == 1) ? !bus.we0 : (g == 2) ? !bus.we1 : 1'b0;
        chk("gnt0", bus.gnt0, g == 1);
        chk("gnt1", bus.gnt1, g == 2);
        chk("mem_we", bus.mem_we, ewe);
        chk("mem_re", bus.mem_re, ere);
        if (g != 0) chk("mem_addr", bus.mem_addr, (g == 1) ? bus.addr0 : bus.addr1);
        if (g != 0 && ewe) chk("mem_din", bus.mem_din, (g == 1) ? bus.wdata0 : bus.wdata1);
        chk("rvalid0", bus.rvalid0, pend0);
        chk("rvalid1", bus.rvalid1, pend1);
        if (pend0) chk("rdata0", bus.rdata0, pdata0);
        if (pend1) chk("rdata1", bus.rdata1, pdata1);
        chk("wait_cnt", dut.wait_cnt_s, streak);
        chk("wait_cnt_le_max", dut.wait_cnt_s <= MAXW, 1);
    endtask

    task automatic model_update();
        int g;
        g = exp_grant();
        last_grant = g;
        pend0 = (g == 1) && !bus.we0;
        pend1 = (g == 2) && !bus.we1;
        if (pend0) pdata0 = ref_mem[int'(bus.addr0)];
        if (pend1) pdata1 = ref_mem[int'(bus.addr1)];
        if (g == 1 && bus.we0) ref_mem[int'(bus.addr0)] = bus.wdata0;
        if (g == 2 && bus.we1) ref_mem[int'(bus.addr1)] = bus.wdata1;
        if (!rst_n) streak = 0;
        else if (bus.req1 && g != 2) streak = (streak < MAXW) ? streak + 1 : MAXW;
        else streak = 0;
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc();
        half();
        clk_edge();
    endtask

    task automatic idle();
        set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        cyc();
    endtask

    initial begin
        int seq [15];
        int exp_seq [15];
        bit a0_pend, a1_pend;
        bit w0, w1;
        logic [15:0] ra0, ra1;
        logic [7:0]  rd0, rd1;

        exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        addr_tab = '{16'h1234, 16'h0010, 16'h0020, 16'h2000,
                     16'h0100, 16'h0101, 16'h0102, 16'h0103};

        // Reset with both requesting
        rst_n = 1'b0;
        set_in(1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00);
        for (int i = 0; i < 3; i++) begin
            half();
            chk("rst_gnt0", bus.gnt0, 0);
            chk("rst_gnt1", bus.gnt1, 0);
            chk("rst_mem_re", bus.mem_re, 0);
            chk("rst_mem_we", bus.mem_we, 0);
            clk_edge();
        end
        rst_n = 1'b1;
        set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("post_rst_rvalid0", bus.rvalid0, 0);
        chk("post_rst_rvalid1", bus.rvalid1, 0);
        clk_edge();

        // Preload through requester 0
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = (i == 0) ? 8'hA5 : (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'($urandom);
            set_in(1, 1, addr_tab[i], d, 0, 0, 16'h0000, 8'h00);
            cyc();
        end
        idle();

        // Single read
        set_in(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("single_gnt0", bus.gnt0, 1);
        clk_edge();
        idle();
        half();
        chk("single_rvalid1", bus.rvalid1, 0);
        clk_edge();
        set_in(1, 0, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        clk_edge();
        set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("single_rvalid0", bus.rvalid0, 1);
        chk("single_rdata0", bus.rdata0, 8'hA5);
        clk_edge();

        // Write by DMA, then CPU read of same address
        set_in(0, 0, 16'h0000, 8'h00, 1, 1, 16'h2000, 8'h3C);
        half();
        chk("wr_gnt1", bus.gnt1, 1);
        clk_edge();
        set_in(1, 0, 16'h2000, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("rd_after_wr_gnt0", bus.gnt0, 1);
        clk_edge();
        set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("rd_after_wr_rvalid0", bus.rvalid0, 1);
        chk("rd_after_wr_rdata0", bus.rdata0, 8'h3C);
        clk_edge();

        // Directed table
        vecs[0] = '{1, 1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00, 1, 0, 1, 0};
        vecs[1] = '{1, 1, 1, 16'h0100, 8'h5A, 1, 0, 16'h0020, 8'h00, 1, 0, 0, 1};
        vecs[2] = '{1, 0, 0, 16'h0000, 8'h00, 1, 1, 16'h0101, 8'h6B, 0, 1, 0, 1};
        vecs[3] = '{1, 0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00, 0, 0, 0, 0};
        vecs[4] = '{0, 1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00, 0, 0, 0, 0};
        vecs[5] = '{1, 0, 0, 16'h0000, 8'h00, 1, 0, 16'h0020, 8'h00, 0, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            rst_n = vecs[i].rst_n;
            set_in(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
                   vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
            half();
            chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vecs[i].exp_gnt0);
            chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vecs[i].exp_gnt1);
            chk($sformatf("vec%0d_mem_re", i), bus.mem_re, vecs[i].exp_re);
            chk($sformatf("vec%0d_mem_we", i), bus.mem_we, vecs[i].exp_we);
            clk_edge();
        end
        rst_n = 1'b1;
        idle();

        // Starvation bound: both requesting continuously
        set_in(1, 0, 16'h0010, 8'h00, 1, 0, 16'h0020, 8'h00);
        for (int i = 0; i < 15; i++) begin
            half();
            seq[i] = bus.gnt1 ? 2 : (bus.gnt0 ? 1 : 0);
            chk("starve_wait_le_max", dut.wait_cnt_s <= MAXW, 1);
            clk_edge();
        end
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("starve_seq%0d", i), seq[i], exp_seq[i]);
        end
        idle();
        idle();

        // Alternating single-cycle reads
        for (int i = 0; i < 7; i++) begin
            if (i == 6) set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
            else if (i % 2 == 0) set_in(1, 0, 16'h0010, 8'h00, 0, 0, 16'h0000, 8'h00);
            else set_in(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0020, 8'h00);
            half();
            if (i < 6) chk("alt_busy", bus.gnt0 | bus.gnt1, 1);
            if (i > 0) begin
                chk("alt_rvalid0", bus.rvalid0, (i - 1) % 2 == 0);
                chk("alt_rvalid1", bus.rvalid1, (i - 1) % 2 == 1);
                if ((i - 1) % 2 == 0) chk("alt_rdata0", bus.rdata0, 8'h11);
                else chk("alt_rdata1", bus.rdata1, 8'h22);
            end
            clk_edge();
        end

        // Reset while a read is requested
        set_in(0, 0, 16'h0000, 8'h00, 1, 0, 16'h0020, 8'h00);
        half();
        clk_edge();
        rst_n = 1'b0;
        set_in(1, 0, 16'h1234, 8'h00, 1, 0, 16'h0020, 8'h00);
        half();
        chk("rst_rd_gnt0", bus.gnt0, 0);
        clk_edge();
        rst_n = 1'b1;
        set_in(0, 0, 16'h0000, 8'h00, 0, 0, 16'h0000, 8'h00);
        half();
        chk("rst_rd_rvalid0", bus.rvalid0, 0);
        chk("rst_rd_wait_cnt", dut.wait_cnt_s, 0);
        clk_edge();

        // Random traffic against the reference model
        a0_pend = 1'b0; a1_pend = 1'b0;
        w0 = 1'b0; w1 = 1'b0; ra0 = 16'h0; ra1 = 16'h0; rd0 = 8'h0; rd1 = 8'h0;
        last_grant = 0;
        for (int c = 0; c < 3000; c++) begin
            if (last_grant == 1) a0_pend = 1'b0;
            if (last_grant == 2) a1_pend = 1'b0;
            if (!a0_pend && $urandom_range(0, 99) < 60) begin
                a0_pend = 1'b1;
                w0  = $urandom_range(0, 2) == 0;
                ra0 = addr_tab[$urandom_range(0, 7)];
                rd0 = 8'($urandom);
            end
            if (!a1_pend && $urandom_range(0, 99) < 50) begin
                a1_pend = 1'b1;
                w1  = $urandom_range(0, 2) == 0;
                ra1 = addr_tab[$urandom_range(0, 7)];
                rd1 = 8'($urandom);
            end
            rst_n = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            set_in(a0_pend, w0, ra0, rd0, a1_pend, w1, ra1, rd1);
            cyc();
        end
        rst_n = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
